// File: rtl/forward_ctrl.sv
// forward_ctrl: EX-stage forwarding selects and IF/ID load-use stall control.
// Keeps a shadow copy of the destination fields for ID/EX, EX/MEM and MEM/WB.
// It advances in lockstep with the datapath pipeline registers.

// Per-operand forwarding select: EX/MEM beats MEM/WB, and $zero is never forwarded.
module fwd_sel (
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_rw,
    input  logic [4:0] wb_rd,
    input  logic       wb_rw,
    output logic [1:0] sel
);
    // Pick the youngest matching producer; 2'b11 is never produced.
    always_comb begin
        sel = 2'b00;
        if (src != 5'd0) begin
            if (mem_rw && mem_rd == src)
                sel = 2'b10;
            else if (wb_rw && wb_rd == src)
                sel = 2'b01;
        end
    end
endmodule

module forward_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_use_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        flush_i,
    output logic [1:0]  fwA_o,
    output logic [1:0]  fwB_o,
    output logic        stall_o,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic [15:0] stall_cnt_o
);
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } idex_t;

    idex_t       ex;
    idex_t       ex_nxt;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [15:0] stall_cnt_q;

    // Operand sources for the instruction in EX: index 0 = A (rs), 1 = B (rt).
    logic [1:0][4:0] op_src;
    logic [1:0][1:0] op_sel;

    assign op_src[0] = ex.rs;
    assign op_src[1] = ex.rt;

    for (genvar g = 0; g < 2; g++) begin : g_op
        fwd_sel u_sel (
            .src    (op_src[g]),
            .mem_rd (mem_rd),
            .mem_rw (mem_regwrite),
            .wb_rd  (wb_rd),
            .wb_rw  (wb_regwrite),
            .sel    (op_sel[g])
        );
    end

    assign fwA_o = op_sel[0];
    assign fwB_o = op_sel[1];

    // Load-use detection against the load in EX; a squashed ID instruction never stalls.
    always_comb begin
        stall_o = 1'b0;
        if (!flush_i && ex.memread && ex.rd != 5'd0 &&
            (ex.rd == id_rs_i || (id_use_rt_i && ex.rd == id_rt_i)))
            stall_o = 1'b1;
    end

    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;
    assign stall_cnt_o  = stall_cnt_q;

    // Next ID/EX content: a bubble on stall or flush, else the decoded ID fields.
    always_comb begin
        ex_nxt          = '0;
        if (!stall_o && !flush_i) begin
            ex_nxt.rs       = id_rs_i;
            ex_nxt.rt       = id_use_rt_i ? id_rt_i : 5'd0;
            ex_nxt.rd       = id_rd_i;
            ex_nxt.regwrite = id_regwrite_i;
            ex_nxt.memread  = id_memread_i;
        end
    end

    // Shadow pipeline advance and saturating stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex           <= '0;
            mem_rd       <= 5'd0;
            mem_regwrite <= 1'b0;
            wb_rd        <= 5'd0;
            wb_regwrite  <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            mem_rd       <= ex.rd;
            mem_regwrite <= ex.regwrite;
            ex           <= ex_nxt;
            if (stall_o && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: a reference model keeps the list of instructions
// that entered EX (youngest first). Stimulus pushes the expected outputs for
// each cycle into a queue, and a monitor compares them on the falling edge.
module tb_forward_ctrl;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
    logic        id_use_rt_i = 1'b0, id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  fwA_o, fwB_o;
    logic        stall_o, pc_write_o, ifid_write_o;
    logic [15:0] stall_cnt_o;

    forward_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_use_rt_i(id_use_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .fwA_o(fwA_o), .fwB_o(fwB_o),
        .stall_o(stall_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       rw, mr;
    } ins_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        st, pcw, ifw;
        logic [15:0] cnt;
    } exp_t;

    exp_t expq[$];
    ins_t hist[$];      // instructions that entered EX, [0] = now in EX
    int   cnt_m = 0;
    logic p_rst = 1'b1, p_st = 1'b0, p_fl = 1'b0;
    ins_t p_id = '0;
    int   tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Forwarding source: the nearest older producer still in flight (MEM, then WB).
    function automatic logic [1:0] fsel(input logic [4:0] x);
        if (x == 0) return 2'b00;
        if (hist[1].rw && hist[1].rd == x) return 2'b10;
        if (hist[2].rw && hist[2].rd == x) return 2'b01;
        return 2'b00;
    endfunction

    // Apply the clock edge to the model using the previous cycle's inputs.
    task automatic model_edge();
        if (p_rst) begin
            hist = {};
            repeat (3) hist.push_back('0);
            cnt_m = 0;
        end else begin
            if (p_st && cnt_m < 65535) cnt_m++;
            hist.push_front((p_st || p_fl) ? ins_t'('0) : p_id);
            void'(hist.pop_back());
        end
    endtask

    // One pipeline cycle: advance model, drive ID inputs, predict outputs.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fl);
        exp_t e;
        ins_t ex;
        @(posedge clk);
        model_edge();
        #1;
        rst_i = rst; id_rs_i = rs; id_rt_i = rt; id_use_rt_i = urt;
        id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
        ex    = hist[0];
        e.fa  = fsel(ex.rs);
        e.fb  = fsel(ex.rt);
        e.st  = !fl && ex.mr && ex.rd != 0 && (ex.rd == rs || (urt && ex.rd == rt));
        e.pcw = !e.st;
        e.ifw = !e.st;
        e.cnt = 16'(cnt_m);
        expq.push_back(e);
        p_rst = rst; p_st = e.st; p_fl = fl;
        p_id  = '{rs: rs, rt: urt ? rt : 5'd0, rd: rd, rw: rw, mr: mr};
    endtask

    task automatic nop();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every cycle's outputs against the predicted record.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("fwA", 16'(fwA_o), 16'(e.fa));
            chk("fwB", 16'(fwB_o), 16'(e.fb));
            chk("stall", 16'(stall_o), 16'(e.st));
            chk("pc_write", 16'(pc_write_o), 16'(e.pcw));
            chk("ifid_write", 16'(ifid_write_o), 16'(e.ifw));
            chk("stall_cnt", stall_cnt_o, e.cnt);
        end
    end

    initial begin
        // Reset state
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        nop(); #2;
        chk("rst_fwA", 16'(fwA_o), 16'd0);
        chk("rst_pcw", 16'(pc_write_o), 16'd1);
        chk("rst_cnt", stall_cnt_o, 16'd0);

        // Back-to-back ALU dependence: add $3 then sub rs=$3
        step(1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd3, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); #2;
        chk("alu_nostall", 16'(stall_o), 16'd0);
        nop(); #2;
        chk("alu_fwA", 16'(fwA_o), 16'd2);

        // Distance-2 via rt
        step(1'b0, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        nop(); #2;
        chk("d2_fwB", 16'(fwB_o), 16'd1);

        // Double match: EX/MEM wins
        step(1'b0, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd2, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd7, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        nop(); #2;
        chk("dbl_fwA", 16'(fwA_o), 16'd2);

        // Load-use: lw $8, add rs=$8 (re-presented after the stall)
        step(1'b0, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #2;
        chk("lu_stall", 16'(stall_o), 16'd1);
        chk("lu_pcw", 16'(pc_write_o), 16'd0);
        chk("lu_ifw", 16'(ifid_write_o), 16'd0);
        step(1'b0, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #2;
        chk("lu_once", 16'(stall_o), 16'd0);
        chk("lu_bubble", 16'(fwA_o), 16'd0);
        nop(); #2;
        chk("lu_fwA", 16'(fwA_o), 16'd1);
        chk("lu_cnt", stall_cnt_o, 16'd1);

        // $zero load never stalls or forwards
        step(1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0); #2;
        chk("z_stall", 16'(stall_o), 16'd0);
        nop(); #2;
        chk("z_fwA", 16'(fwA_o), 16'd0);
        chk("z_fwB", 16'(fwB_o), 16'd0);

        // Flush beats stall
        step(1'b0, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd9, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1); #2;
        chk("fl_stall", 16'(stall_o), 16'd0);
        nop(); #2;
        chk("fl_cnt", stall_cnt_o, 16'd1);

        // Reset in the middle of a stall
        step(1'b0, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #2;
        chk("rs_stall_seen", 16'(stall_o), 16'd1);
        nop(); #2;
        chk("rs_stall", 16'(stall_o), 16'd0);
        chk("rs_ifw", 16'(ifid_write_o), 16'd1);
        chk("rs_cnt", stall_cnt_o, 16'd0);

        // Randomized traffic over a small register range for frequent hazards
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        // Saturation: preload the counter near the top, then keep stalling
        nop();
        force dut.stall_cnt_q = 16'hFFF0;
        cnt_m = 16'hFFF0;
        expq[expq.size() - 1].cnt = 16'hFFF0;
        #1 release dut.stall_cnt_q;
        for (int i = 0; i < 40; i++)
            step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        nop(); #2;
        chk("sat_cnt", stall_cnt_o, 16'hFFFF);

        nop();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
